// File: rtl/uart_transmitter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_transmitter : 8E1 UART transmitter with selectable baud rate.
// Rev 1.0 -- initial release
// ---------------------------------------------------------------------------
module uart_transmitter #(
   parameter int CLK_HZ = 50000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] baud_select,
   input  logic       Tx_EN,
   input  logic       Tx_WR,
   input  logic [7:0] Tx_DATA,
   output logic       TxD,
   output logic       Tx_BUSY
);

   localparam int c_DIV_W = $clog2((CLK_HZ + 2400) / 4800 + 1);

   localparam logic [2:0] c_IDLE   = 3'd0;
   localparam logic [2:0] c_START  = 3'd1;
   localparam logic [2:0] c_DATA   = 3'd2;
   localparam logic [2:0] c_PARITY = 3'd3;
   localparam logic [2:0] c_STOP   = 3'd4;

   // Rounded divisor: round(CLK_HZ / (16 * baud)).
   function automatic logic [c_DIV_W-1:0] div_of(input logic [2:0] sel);
      int baud;
      case (sel)
         3'd0:    baud = 300;
         3'd1:    baud = 1200;
         3'd2:    baud = 4800;
         3'd3:    baud = 9600;
         3'd4:    baud = 19200;
         3'd5:    baud = 38400;
         3'd6:    baud = 57600;
         default: baud = 115200;
      endcase
      return c_DIV_W'((CLK_HZ + 8 * baud) / (16 * baud));
   endfunction

   logic [2:0]         r_state;
   logic [c_DIV_W-1:0] r_div_cnt;
   logic [3:0]         r_tick_cnt;
   logic [3:0]         r_bit_idx;
   logic [7:0]         r_data;
   logic [2:0]         r_baud;
   logic               r_txd;
   logic               r_busy;

   logic [c_DIV_W-1:0] w_div_last;
   logic               w_tick;
   logic               w_bit_end;
   logic               w_accept;
   logic [2:0]         w_state_next;
   logic [3:0]         w_idx_next;
   logic               w_txd_next;
   logic               w_busy_next;

   assign w_div_last = div_of(r_baud) - c_DIV_W'(1);
   assign w_tick     = (r_div_cnt == w_div_last);
   assign w_bit_end  = w_tick && (r_tick_cnt == 4'd15);
   assign w_accept   = (r_state == c_IDLE) && Tx_WR && Tx_EN;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= c_IDLE;
      else        r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:   if (w_accept) w_state_next = c_START;
         c_START:  if (w_bit_end) w_state_next = c_DATA;
         c_DATA:   if (w_bit_end && (r_bit_idx == 4'd7)) w_state_next = c_PARITY;
         c_PARITY: if (w_bit_end) w_state_next = c_STOP;
         c_STOP:   if (w_bit_end) w_state_next = c_IDLE;
         default:  w_state_next = c_IDLE;
      endcase
      // Dropping the enable aborts any frame in flight.
      if ((r_state != c_IDLE) && !Tx_EN) w_state_next = c_IDLE;
   end

   always_comb begin
      w_idx_next = r_bit_idx;
      if (w_state_next != c_DATA)
         w_idx_next = 4'd0;
      else if ((r_state == c_DATA) && w_bit_end)
         w_idx_next = r_bit_idx + 4'd1;
   end

   // Line level is computed for the upcoming state so the register lines up with it.
   always_comb begin
      w_txd_next  = 1'b1;
      w_busy_next = 1'b1;
      case (w_state_next)
         c_IDLE:   w_busy_next = 1'b0;
         c_START:  w_txd_next  = 1'b0;
         c_DATA:   w_txd_next  = r_data[w_idx_next[2:0]];
         c_PARITY: w_txd_next  = ^r_data;
         c_STOP:   w_txd_next  = 1'b1;
         default:  w_busy_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_div_cnt  <= '0;
         r_tick_cnt <= 4'd0;
         r_bit_idx  <= 4'd0;
         r_data     <= 8'd0;
         r_baud     <= 3'd0;
         r_txd      <= 1'b1;
         r_busy     <= 1'b0;
      end else begin
         r_bit_idx <= w_idx_next;
         r_txd     <= w_txd_next;
         r_busy    <= w_busy_next;
         if (w_accept || (w_state_next == c_IDLE)) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= 4'd0;
         end else if (w_tick) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= r_tick_cnt + 4'd1;
         end else begin
            r_div_cnt  <= r_div_cnt + c_DIV_W'(1);
         end
         if (w_accept) begin
            r_data <= Tx_DATA;
            r_baud <= baud_select;
         end
      end
   end

   assign TxD     = r_txd;
   assign Tx_BUSY = r_busy;

endmodule
`default_nettype wire
